// File: rtl/regfile_wb.sv
// Integer register file and write-back sink with a post-reset clear sequencer.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb #(
  parameter  int XLEN    = 32,
  parameter  int REG_NUM = 32,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rd_wr_en_i,
  input  logic [AW-1:0]   rd_wr_addr_i,
  input  logic [XLEN-1:0] rd_wr_data_i,
  input  logic [AW-1:0]   rs1_rd_addr_i,
  input  logic [AW-1:0]   rs2_rd_addr_i,
  output logic [XLEN-1:0] rs1_rd_data_o,
  output logic [XLEN-1:0] rs2_rd_data_o,
  output logic            ready_o
);

  localparam logic [0:0]    CLEAR    = 1'b0;
  localparam logic [0:0]    RUN      = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);
  localparam logic [AW-1:0] ZERO_IDX = '0;

  logic [0:0]      state;
  logic [AW-1:0]   clr_cnt;
  logic            ready;
  logic [XLEN-1:0] regs [REG_NUM];
  logic            wr_ok;
  logic            fwd1;
  logic            fwd2;

  // The counter stops at the top index instead of wrapping, and RUN holds it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CLEAR;
      clr_cnt <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  assign wr_ok = (state == RUN) && rd_wr_en_i && (rd_wr_addr_i != ZERO_IDX);

  // No per-entry reset: the clear sequence is the only initialiser.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) begin
        regs[clr_cnt] <= '0;
      end else if (wr_ok) begin
        regs[rd_wr_addr_i] <= rd_wr_data_i;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = rd_wr_en_i && ready && (rd_wr_addr_i != ZERO_IDX) && (rd_wr_addr_i == rs1_rd_addr_i);
  assign fwd2 = rd_wr_en_i && ready && (rd_wr_addr_i != ZERO_IDX) && (rd_wr_addr_i == rs2_rd_addr_i);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Not-ready and x0 zeroing override any forwarded value.
  always_comb begin
    rs1_rd_data_o = '0;
    rs2_rd_data_o = '0;
    if (ready && (rs1_rd_addr_i != ZERO_IDX)) begin
      rs1_rd_data_o = fwd1 ? rd_wr_data_i : regs[rs1_rd_addr_i];
    end
    if (ready && (rs2_rd_addr_i != ZERO_IDX)) begin
      rs2_rd_data_o = fwd2 ? rd_wr_data_i : regs[rs2_rd_addr_i];
    end
  end

  assign ready_o = ready;

endmodule
